// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_t   : 2-bit FSM state encoding (IDLE / ADD / DONE)
//   cnt_width : bit-counter width for a given operand width, max(1, clog2(width))
package serial_adder_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/adder_bit_slice.sv
// Combinational full-adder bit slice built from two half adders and an OR.
//   a, b : operand bits
//   cin  : carry in
//   sum  : a ^ b ^ cin
//   cout : carry out
module adder_bit_slice (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic s1;
   logic c1;
   logic c2;

   half_adder ha0 (
      .a     (a),
      .b     (b),
      .sum   (s1),
      .carry (c1)
   );

   half_adder ha1 (
      .a     (s1),
      .b     (cin),
      .sum   (sum),
      .carry (c2)
   );

   assign cout = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder.
//   a, b  : input bits
//   sum   : a ^ b
//   carry : a & b
module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b;
   assign carry = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared full-adder slice, one bit per clock,
// LSB first. Operands are captured on an accepted start, WIDTH add cycles
// follow, then the registered sum/carry are presented with a one-cycle done.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_start           : start request, accepted only while o_ready
//   i_a, i_b, i_cin   : operands and carry-in, captured on accept
//   o_ready           : idle, a start is accepted this cycle
//   o_busy            : add cycles in progress
//   o_done            : one-cycle pulse, result valid from this cycle
//   o_sum, o_cout     : registered result, held until the next done
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic             o_ready,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic [WIDTH-1:0] sum_shifted;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             last_bit;
   logic             sum_bit;
   logic             carry_next;

   adder_bit_slice u_slice (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .sum  (sum_bit),
      .cout (carry_next)
   );

   assign last_bit = (cnt == CW'(WIDTH - 1));

   // New bit enters at the MSB; truncating the concatenation keeps this
   // valid for WIDTH=1, where the result is just the new bit.
   assign sum_shifted = WIDTH'({sum_bit, sum_sr} >> 1);

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE:  if (i_start) state_next = S_ADD;
         S_ADD:   if (last_bit) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      o_ready = 1'b0;
      o_busy  = 1'b0;
      o_done  = 1'b0;
      unique case (state)
         S_IDLE:  o_ready = 1'b1;
         S_ADD:   o_busy  = 1'b1;
         S_DONE:  o_done  = 1'b1;
         default: o_ready = 1'b0;
      endcase
   end

   // Datapath: operand shifters, carry flop, bit counter, result registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         o_sum  <= '0;
         o_cout <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (i_start) begin
                  a_sr   <= i_a;
                  b_sr   <= i_b;
                  sum_sr <= '0;
                  carry  <= i_cin;
                  cnt    <= '0;
               end
            end
            S_ADD: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               sum_sr <= sum_shifted;
               carry  <= carry_next;
               if (last_bit) begin
                  o_sum  <= sum_shifted;
                  o_cout <= carry_next;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1. Expected
// results are queued when a start is accepted and compared when done pulses.
module tb_serial_adder_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       st8, c8, rdy8, busy8, done8, cout8;
   logic [7:0] a8, b8, sum8;
   logic       st1, c1, rdy1, busy1, done1, cout1;
   logic [0:0] a1, b1, sum1;

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .i_clk(clk), .i_rst(rst), .i_start(st8), .i_a(a8), .i_b(b8), .i_cin(c8),
      .o_ready(rdy8), .o_busy(busy8), .o_done(done8), .o_sum(sum8), .o_cout(cout8)
   );

   serial_adder_ctrl #(.WIDTH(1)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_start(st1), .i_a(a1), .i_b(b1), .i_cin(c1),
      .o_ready(rdy1), .o_busy(busy1), .o_done(done1), .o_sum(sum1), .o_cout(cout1)
   );

   typedef struct packed {
      logic [8:0] res;
      int         e0;
   } exp_t;

   exp_t q8[$];
   exp_t q1[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   done8_cnt = 0;
   int   acc8_cnt = 0;
   int   done1_cnt = 0;
   bit   last_acc8;
   int   done8_cyc[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: queue expectations for accepted starts, advance, then
   // compare any done pulse against the scoreboard.
   task automatic step();
      exp_t e;
      bit   r;
      bit   acc1;
      r         = rst;
      last_acc8 = rdy8 && st8 && !rst;
      acc1      = rdy1 && st1 && !rst;
      if (last_acc8) begin
         e.res = 9'(a8) + 9'(b8) + 9'(c8);
         e.e0  = cyc + 1;
         q8.push_back(e);
         acc8_cnt++;
      end
      if (acc1) begin
         e.res = 9'(a1) + 9'(b1) + 9'(c1);
         e.e0  = cyc + 1;
         q1.push_back(e);
      end
      @(posedge clk);
      cyc++;
      if (r) begin
         q8.delete();
         q1.delete();
      end
      #1;
      if (done8) begin
         done8_cnt++;
         done8_cyc.push_back(cyc);
         if (q8.size() == 0) begin
            check("done8_unexpected", 64'(done8), 64'd0);
         end else begin
            e = q8.pop_front();
            check("sum8", 64'({cout8, sum8}), 64'(e.res));
            check("latency8", 64'(cyc - e.e0), 64'd8);
         end
      end
      if (done1) begin
         done1_cnt++;
         if (q1.size() == 0) begin
            check("done1_unexpected", 64'(done1), 64'd0);
         end else begin
            e = q1.pop_front();
            check("sum1", 64'({cout1, sum1}), 64'(e.res));
            check("latency1", 64'(cyc - e.e0), 64'd1);
         end
      end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c);
      a8 = a; b8 = b; c8 = c; st8 = 1'b1;
      step();
      st8 = 1'b0;
      steps(9);
      check("op8_ready_after", 64'(rdy8), 64'd1);
   endtask

   initial begin
      int d0;
      int idx;
      logic [16:0] tbl [3];
      tbl[0] = {8'h10, 8'h20, 1'b0};
      tbl[1] = {8'hF0, 8'h20, 1'b1};
      tbl[2] = {8'h7F, 8'h7F, 1'b1};

      rst = 1'b1;
      st8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
      st1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
      steps(2);
      check("rst_ready8", 64'(rdy8), 64'd1);
      check("rst_busy8",  64'(busy8), 64'd0);
      check("rst_done8",  64'(done8), 64'd0);
      check("rst_res8",   64'({cout8, sum8}), 64'd0);
      check("rst_ready1", 64'(rdy1), 64'd1);
      check("rst_res1",   64'({cout1, sum1}), 64'd0);
      rst = 1'b0;
      step();

      // FF + 01: walk the timing cycle by cycle
      a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; st8 = 1'b1;
      step();
      st8 = 1'b0;
      check("add_busy_first", 64'(busy8), 64'd1);
      check("add_ready_first", 64'(rdy8), 64'd0);
      steps(7);
      check("add_busy_last", 64'(busy8), 64'd1);
      check("add_done_early", 64'(done8), 64'd0);
      step();
      check("done_pulse", 64'(done8), 64'd1);
      check("done_busy", 64'(busy8), 64'd0);
      check("done_ready", 64'(rdy8), 64'd0);
      step();
      check("idle_ready", 64'(rdy8), 64'd1);
      check("done_single", 64'(done8), 64'd0);
      check("result_hold", 64'({cout8, sum8}), 64'h100);

      op8(8'h5A, 8'hA5, 1'b1);
      op8(8'h12, 8'h34, 1'b0);
      check("result_46", 64'({cout8, sum8}), 64'h046);

      // Start pulses during ADD and DONE are ignored
      d0 = done8_cnt;
      a8 = 8'h3C; b8 = 8'h0F; c8 = 1'b1; st8 = 1'b1;
      step();
      st8 = 1'b0;
      steps(2);
      a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; st8 = 1'b1;
      step();
      st8 = 1'b0;
      steps(5);
      check("ign_done", 64'(done8), 64'd1);
      a8 = 8'h77; b8 = 8'h77; st8 = 1'b1;
      step();
      st8 = 1'b0;
      check("ign_ready", 64'(rdy8), 64'd1);
      steps(12);
      check("ign_done_count", 64'(done8_cnt - d0), 64'd1);
      check("ign_result", 64'({cout8, sum8}), 64'h04C);

      // Reset during the fourth ADD cycle aborts the operation
      d0 = done8_cnt;
      a8 = 8'h81; b8 = 8'h7F; c8 = 1'b0; st8 = 1'b1;
      step();
      st8 = 1'b0;
      steps(3);
      check("abort_busy", 64'(busy8), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_ready", 64'(rdy8), 64'd1);
      check("abort_busy_low", 64'(busy8), 64'd0);
      check("abort_done", 64'(done8), 64'd0);
      check("abort_res", 64'({cout8, sum8}), 64'd0);
      steps(12);
      check("abort_no_done", 64'(done8_cnt - d0), 64'd0);
      op8(8'h81, 8'h7F, 1'b0);
      op8(8'hC8, 8'h64, 1'b1);

      // Reset and start in the same cycle: start is dropped
      d0 = done8_cnt;
      a8 = 8'h11; b8 = 8'h22; st8 = 1'b1; rst = 1'b1;
      step();
      st8 = 1'b0; rst = 1'b0;
      check("rst_start_ready", 64'(rdy8), 64'd1);
      step();
      check("rst_start_busy", 64'(busy8), 64'd0);
      steps(10);
      check("rst_start_no_done", 64'(done8_cnt - d0), 64'd0);

      // Start held high: accepts every WIDTH+2 cycles
      done8_cyc.delete();
      d0  = acc8_cnt;
      idx = 0;
      {a8, b8, c8} = tbl[0];
      st8 = 1'b1;
      for (int k = 0; k < 29; k++) begin
         step();
         if (last_acc8) begin
            idx++;
            if (idx < 3) {a8, b8, c8} = tbl[idx];
         end
      end
      st8 = 1'b0;
      steps(2);
      check("b2b_accepts", 64'(acc8_cnt - d0), 64'd3);
      check("b2b_dones", 64'(done8_cyc.size()), 64'd3);
      if (done8_cyc.size() == 3) begin
         check("b2b_gap1", 64'(done8_cyc[1] - done8_cyc[0]), 64'd10);
         check("b2b_gap2", 64'(done8_cyc[2] - done8_cyc[1]), 64'd10);
      end

      // WIDTH=1: all input combinations
      d0 = done1_cnt;
      for (int i = 0; i < 8; i++) begin
         a1 = 1'(i >> 2); b1 = 1'(i >> 1); c1 = 1'(i);
         st1 = 1'b1;
         step();
         st1 = 1'b0;
         check("w1_busy", 64'(busy1), 64'd1);
         step();
         step();
         check("w1_ready", 64'(rdy1), 64'd1);
      end
      check("w1_done_count", 64'(done1_cnt - d0), 64'd8);

      check("pending8", 64'(q8.size()), 64'd0);
      check("pending1", 64'(q1.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
